// File: rtl/nyq_upsampler.sv
// -----------------------------------------------------------------------------
// nyq_upsampler
//   Upstream feeder of the NYQ pulse-shaping filter. Signed symbols arrive over
//   a valid/ready handshake and are buffered in a small FIFO. The block then
//   zero-stuffs them by a runtime factor L and emits one sample every clock.
//   UPS_Out_DO connects directly to NYQ_In_DI. Configuration shares the NYQ
//   WrEn/Addr/PAR_In bus and uses addresses 0 and 1.
//
//   Config map:
//     addr 0 : L = PAR_In_DI[4:0] (a value of 0 is stored as 1)
//     addr 1 : bit0 = En, bit1 = ClrUf (a one-shot that clears Underflow_SO)
//
//   Optional feature (macro UPS_GAIN_EN):
//     When defined, each phase-0 sample is head * L, saturated symmetrically to
//     +/-(2**(OUT_WIDTH-1)-1). This restores the 1/L gain lost by zero-stuffing.
//     When undefined, each phase-0 sample is the sign-extended head.
//
// Ports:
//   Clk_CI        clock; all logic runs on the rising edge
//   Rst_RBI       asynchronous active-low reset
//   WrEn_SI       config write strobe
//   Addr_DI       config address
//   PAR_In_DI     config write data
//   Sym_In_DI     input symbol (signed)
//   SymValid_SI   symbol valid
//   SymReady_SO   FIFO not full (combinational from the occupancy count)
//   UPS_Out_DO    registered output sample to NYQ
//   SymStrb_SO    registered; high when UPS_Out_DO carries a phase-0 slot
//   Underflow_SO  sticky; set when a phase-0 slot finds the FIFO empty in RUN
// -----------------------------------------------------------------------------
module nyq_upsampler #(
   parameter int ADDR_WIDTH = 5,
   parameter int MEM_WIDTH  = 24,
   parameter int IN_WIDTH   = 24,
   parameter int OUT_WIDTH  = 24,
   parameter int FIFO_AW    = 2,
   parameter int PRIME_LVL  = 2
) (
   input  logic                  Clk_CI,
   input  logic                  Rst_RBI,
   input  logic                  WrEn_SI,
   input  logic [ADDR_WIDTH-1:0] Addr_DI,
   input  logic [MEM_WIDTH-1:0]  PAR_In_DI,
   input  logic [IN_WIDTH-1:0]   Sym_In_DI,
   input  logic                  SymValid_SI,
   output logic                  SymReady_SO,
   output logic [OUT_WIDTH-1:0]  UPS_Out_DO,
   output logic                  SymStrb_SO,
   output logic                  Underflow_SO
);

   localparam int DEPTH = 2 ** FIFO_AW;

   typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_RUN} state_t;

   state_t                      state, state_nxt;
   logic [4:0]                  l_reg, l_act, l_cur;
   logic [4:0]                  phase, phase_nxt;
   logic                        en, uf;
   logic                        cfg_l, cfg_ctl, uf_set, uf_clr;

   logic signed [IN_WIDTH-1:0]  mem [DEPTH];
   logic [FIFO_AW-1:0]          wr_ptr, rd_ptr;
   logic [FIFO_AW:0]            count;
   logic                        full, empty, push, pop, flush, slot0;
   logic signed [IN_WIDTH-1:0]  head;

   logic signed [OUT_WIDTH-1:0] sample_p0, sample_p1;
   logic                        strb_p0, strb_p1;

   // Only the low five data bits carry configuration.
   logic                        unused_par;
   assign unused_par = ^PAR_In_DI[MEM_WIDTH-1:5];

   function automatic logic signed [OUT_WIDTH-1:0] sext(input logic signed [IN_WIDTH-1:0] sym);
      return OUT_WIDTH'(sym);
   endfunction

`ifdef UPS_GAIN_EN
   // The product is held wide enough that the saturation compare never wraps.
   localparam int PW = (IN_WIDTH + 6 > OUT_WIDTH) ? IN_WIDTH + 6 : OUT_WIDTH + 1;
   localparam logic signed [PW-1:0] SAT_MAX = {{(PW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [PW-1:0] SAT_MIN = -SAT_MAX;

   function automatic logic signed [OUT_WIDTH-1:0] sat_gain(input logic signed [IN_WIDTH-1:0] sym,
                                                            input logic [4:0] l);
      logic signed [PW-1:0] prod;
      prod = PW'(sym) * $signed(PW'({1'b0, l}));
      if (prod > SAT_MAX)
         return SAT_MAX[OUT_WIDTH-1:0];
      else if (prod < SAT_MIN)
         return SAT_MIN[OUT_WIDTH-1:0];
      return prod[OUT_WIDTH-1:0];
   endfunction
`endif

   // Config decode
   assign cfg_l   = WrEn_SI && (Addr_DI == ADDR_WIDTH'(0));
   assign cfg_ctl = WrEn_SI && (Addr_DI == ADDR_WIDTH'(1));
   assign uf_clr  = cfg_ctl && PAR_In_DI[1];

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         l_reg <= 5'd1;
         en    <= 1'b0;
         uf    <= 1'b0;
      end else begin
         if (cfg_l)
            l_reg <= (PAR_In_DI[4:0] == 5'd0) ? 5'd1 : PAR_In_DI[4:0];
         if (cfg_ctl)
            en <= PAR_In_DI[0];
         // A new underflow in the same cycle as a clear leaves the flag set.
         if (uf_set)
            uf <= 1'b1;
         else if (uf_clr)
            uf <= 1'b0;
      end
   end

   // FIFO status and handshake. Disabling flushes the FIFO on the next edge.
   // In IDLE the FIFO is empty, so SymReady_SO reads 1, but no push is taken.
   assign full  = (count == (FIFO_AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign flush = !en;
   assign push  = SymValid_SI && !full && (state != ST_IDLE);
   assign slot0 = (state == ST_RUN) && (phase == 5'd0) && en;
   assign pop   = slot0 && !empty;
   assign uf_set = slot0 && empty;
   assign head  = mem[rd_ptr];

   assign SymReady_SO  = !full;
   assign Underflow_SO = uf;

   always_ff @(posedge Clk_CI) begin
      if (push && !flush)
         mem[wr_ptr] <= $signed(Sym_In_DI);
   end

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + FIFO_AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (FIFO_AW+1)'(1);
            2'b01:   count <= count - (FIFO_AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // FSM
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (en) state_nxt = ST_PRIME;
         ST_PRIME: if (count >= (FIFO_AW+1)'(PRIME_LVL)) state_nxt = ST_RUN;
         ST_RUN:   state_nxt = ST_RUN;
         default:  state_nxt = ST_IDLE;
      endcase
      if (!en)
         state_nxt = ST_IDLE;
   end

   // Phase counter. A period's length is taken from l_reg at its phase-0 cycle.
   // A mid-period write therefore only affects the next period.
   assign l_cur     = (phase == 5'd0) ? l_reg : l_act;
   assign phase_nxt = (phase == l_cur - 5'd1) ? 5'd0 : phase + 5'd1;

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         phase <= 5'd0;
         l_act <= 5'd1;
      end else begin
         if (phase == 5'd0)
            l_act <= l_reg;
         if ((state == ST_RUN) && (state_nxt == ST_RUN))
            phase <= phase_nxt;
         else
            phase <= 5'd0;
      end
   end

   // Stage p0: select the FIFO head (scaled, when gain is enabled) in phase-0 slots
   always_comb begin
      sample_p0 = '0;
      strb_p0   = slot0;
      if (pop) begin
`ifdef UPS_GAIN_EN
         sample_p0 = sat_gain(head, l_cur);
`else
         sample_p0 = sext(head);
`endif
      end
   end

   // Stage p1: registered output to NYQ
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         sample_p1 <= '0;
         strb_p1   <= 1'b0;
      end else begin
         sample_p1 <= sample_p0;
         strb_p1   <= strb_p0;
      end
   end

   assign UPS_Out_DO = sample_p1;
   assign SymStrb_SO = strb_p1;

endmodule

// File: tb/tb_nyq_upsampler.sv
// -----------------------------------------------------------------------------
// tb_nyq_upsampler
//   Self-checking bench for nyq_upsampler. A behavioural model predicts each
//   output cycle. The model holds a queue of buffered symbols, a run mode, and
//   a count of slots left in the current period. Scenario tasks drive
//   randomized symbols and compare the DUT cycle by cycle, and also against
//   hand-derived sequences.
// -----------------------------------------------------------------------------
module tb_nyq_upsampler;

   localparam int DEPTH = 4;
   localparam int PLVL  = 2;
   localparam int SMAX  = 8388607;

   logic        Clk_CI = 1'b0;
   logic        Rst_RBI;
   logic        WrEn_SI;
   logic [4:0]  Addr_DI;
   logic [23:0] PAR_In_DI;
   logic [23:0] Sym_In_DI;
   logic        SymValid_SI;
   logic        SymReady_SO;
   logic [23:0] UPS_Out_DO;
   logic        SymStrb_SO;
   logic        Underflow_SO;

   always #5 Clk_CI = ~Clk_CI;

   nyq_upsampler dut (
      .Clk_CI      (Clk_CI),
      .Rst_RBI     (Rst_RBI),
      .WrEn_SI     (WrEn_SI),
      .Addr_DI     (Addr_DI),
      .PAR_In_DI   (PAR_In_DI),
      .Sym_In_DI   (Sym_In_DI),
      .SymValid_SI (SymValid_SI),
      .SymReady_SO (SymReady_SO),
      .UPS_Out_DO  (UPS_Out_DO),
      .SymStrb_SO  (SymStrb_SO),
      .Underflow_SO(Underflow_SO)
   );

   int checks   = 0;
   int failures = 0;

   // Behavioural model state
   typedef enum {M_IDLE, M_PRIME, M_RUN} mmode_t;
   mmode_t m_mode;
   int     m_L, m_en, m_left;
   int     q[$];
   int     src[$];
   int     gap_pct;
   int     e_out;
   bit     e_strb, e_ready, e_uf;

   function automatic int gain_of(input int sym, input int l);
`ifdef UPS_GAIN_EN
      longint p;
      p = longint'(sym) * longint'(l);
      if (p > SMAX) return SMAX;
      if (p < -SMAX) return -SMAX;
      return int'(p);
`else
      return sym + 0 * l;
`endif
   endfunction

   function automatic int rand_sym();
      logic [23:0] t;
      t = 24'($urandom);
      return int'($signed(t));
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE; m_L = 1; m_en = 0; m_left = 0;
      e_out = 0; e_strb = 0; e_ready = 1; e_uf = 0;
      q.delete(); src.delete();
   endtask

   // Predicts the outputs right after the next rising edge, given current inputs.
   task automatic model_edge();
      int ql;
      bit acc, set_uf, clr_uf;
      int sym;
      ql     = q.size();
      sym    = int'($signed(Sym_In_DI));
      acc    = SymValid_SI && (ql < DEPTH) && (m_mode != M_IDLE);
      clr_uf = WrEn_SI && (Addr_DI == 5'd1) && PAR_In_DI[1];
      set_uf = 0;
      if (acc) void'(src.pop_front());
      if (m_en == 0) begin
         m_mode = M_IDLE; q.delete(); e_out = 0; e_strb = 0; m_left = 0;
      end else begin
         case (m_mode)
            M_IDLE: begin
               m_mode = M_PRIME; e_out = 0; e_strb = 0;
            end
            M_PRIME: begin
               e_out = 0; e_strb = 0;
               if (ql >= PLVL) begin m_mode = M_RUN; m_left = 0; end
               if (acc) q.push_back(sym);
            end
            default: begin
               if (m_left == 0) begin
                  if (q.size() > 0) e_out = gain_of(q.pop_front(), m_L);
                  else begin e_out = 0; set_uf = 1; end
                  e_strb = 1;
                  m_left = m_L - 1;
               end else begin
                  e_out = 0; e_strb = 0; m_left--;
               end
               if (acc) q.push_back(sym);
            end
         endcase
      end
      if (clr_uf) e_uf = 0;
      if (set_uf) e_uf = 1;
      if (WrEn_SI && Addr_DI == 5'd0) m_L = (PAR_In_DI[4:0] == 0) ? 1 : int'(PAR_In_DI[4:0]);
      if (WrEn_SI && Addr_DI == 5'd1) m_en = int'(PAR_In_DI[0]);
      e_ready = (q.size() < DEPTH);
   endtask

   // One clock: drive inputs, advance model, sample 1 time unit after the edge.
   task automatic step(input logic wr, input logic [4:0] addr, input logic [23:0] data);
      logic [23:0] t;
      WrEn_SI = wr; Addr_DI = addr; PAR_In_DI = data;
      if (src.size() > 0 && $urandom_range(99) >= gap_pct) begin
         SymValid_SI = 1'b1;
         t = 24'(src[0]);
         Sym_In_DI = t;
      end else begin
         SymValid_SI = 1'b0;
         Sym_In_DI = 24'($urandom);
      end
      model_edge();
      @(posedge Clk_CI); #1;
      WrEn_SI = 1'b0; SymValid_SI = 1'b0;
   endtask

   task automatic do_reset();
      Rst_RBI = 1'b0;
      #3;
      Rst_RBI = 1'b1;
      @(posedge Clk_CI); #1;
      model_reset();
      gap_pct = 0;
   endtask

   task automatic test_reset();
      logic [23:0] eo;
      // Power-on reset
      if (SymReady_SO !== 1'b1 || UPS_Out_DO !== 24'd0 || SymStrb_SO !== 1'b0 || Underflow_SO !== 1'b0) begin
         failures++;
         $display("FAIL reset_por: rdy=%b out=%0d strb=%b uf=%b, expected rdy=1 out=0 strb=0 uf=0",
                  SymReady_SO, $signed(UPS_Out_DO), SymStrb_SO, Underflow_SO);
      end
      checks++;
      #3 Rst_RBI = 1'b1;
      @(posedge Clk_CI); #1;
      model_reset();
      step(1, 0, 3); step(1, 1, 1);
      for (int i = 0; i < 6; i++) src.push_back(rand_sym());
      for (int i = 0; i < 14; i++) begin
         step(0, 0, 0);
         eo = 24'(e_out);
         if (UPS_Out_DO !== eo || SymStrb_SO !== e_strb || SymReady_SO !== e_ready || Underflow_SO !== e_uf) begin
            failures++;
            $display("FAIL reset_run: out=%0d strb=%b rdy=%b uf=%b, expected out=%0d strb=%b rdy=%b uf=%b",
                     $signed(UPS_Out_DO), SymStrb_SO, SymReady_SO, Underflow_SO, e_out, e_strb, e_ready, e_uf);
         end
         checks++;
      end
      // Asynchronous reset in the middle of a cycle while running
      #2 Rst_RBI = 1'b0;
      #1;
      if (SymReady_SO !== 1'b1 || UPS_Out_DO !== 24'd0 || SymStrb_SO !== 1'b0 || Underflow_SO !== 1'b0) begin
         failures++;
         $display("FAIL reset_async: rdy=%b out=%0d strb=%b uf=%b, expected rdy=1 out=0 strb=0 uf=0",
                  SymReady_SO, $signed(UPS_Out_DO), SymStrb_SO, Underflow_SO);
      end
      checks++;
      #1 Rst_RBI = 1'b1;
      @(posedge Clk_CI); #1;
      model_reset();
      // En is cleared by reset: the block must stay silent until En is rewritten
      for (int i = 0; i < 3; i++) src.push_back(rand_sym());
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 0);
         if (UPS_Out_DO !== 24'd0 || SymStrb_SO !== 1'b0 || SymReady_SO !== e_ready) begin
            failures++;
            $display("FAIL reset_idle: out=%0d strb=%b rdy=%b, expected out=0 strb=0 rdy=%b",
                     $signed(UPS_Out_DO), SymStrb_SO, SymReady_SO, e_ready);
         end
         checks++;
      end
   endtask

   task automatic test_basic();
      int syms[3];
      int got[$];
      bit rec;
      logic [23:0] eo;
      int ex;
      do_reset();
      syms[0] = 100; syms[1] = -5; syms[2] = 7;
      step(1, 0, 4); step(1, 1, 1);
      for (int i = 0; i < 3; i++) src.push_back(syms[i]);
      rec = 0;
      for (int i = 0; i < 24; i++) begin
         step(0, 0, 0);
         eo = 24'(e_out);
         if (UPS_Out_DO !== eo || SymStrb_SO !== e_strb || SymReady_SO !== e_ready || Underflow_SO !== e_uf) begin
            failures++;
            $display("FAIL basic_cycle: out=%0d strb=%b rdy=%b uf=%b, expected out=%0d strb=%b rdy=%b uf=%b",
                     $signed(UPS_Out_DO), SymStrb_SO, SymReady_SO, Underflow_SO, e_out, e_strb, e_ready, e_uf);
         end
         checks++;
         if (SymStrb_SO) rec = 1;
         if (rec) got.push_back(SymStrb_SO ? int'($signed(UPS_Out_DO)) : (int'($signed(UPS_Out_DO)) + 1000000));
      end
      if (got.size() < 12) begin
         failures++;
         $display("FAIL basic_len: collected %0d samples, expected at least 12", got.size());
         checks++;
      end else begin
         // Expected: each symbol on a strobe, then three plain zeros
         for (int i = 0; i < 12; i++) begin
            ex = (i % 4 == 0) ? gain_of(syms[i/4], 4) : 1000000;
            if (got[i] !== ex) begin
               failures++;
               $display("FAIL basic_seq[%0d]: got code %0d, expected %0d", i, got[i], ex);
            end
            checks++;
         end
      end
   endtask

   task automatic test_underflow();
      logic [23:0] eo;
      bit hit;
      do_reset();
      step(1, 0, 2); step(1, 1, 1);
      src.push_back(rand_sym()); src.push_back(rand_sym());
      for (int pass = 0; pass < 2; pass++) begin
         hit = 0;
         for (int i = 0; i < 40 && !hit; i++) begin
            step(0, 0, 0);
            eo = 24'(e_out);
            if (UPS_Out_DO !== eo || SymStrb_SO !== e_strb || SymReady_SO !== e_ready || Underflow_SO !== e_uf) begin
               failures++;
               $display("FAIL uf_cycle: out=%0d strb=%b rdy=%b uf=%b, expected out=%0d strb=%b rdy=%b uf=%b",
                        $signed(UPS_Out_DO), SymStrb_SO, SymReady_SO, Underflow_SO, e_out, e_strb, e_ready, e_uf);
            end
            checks++;
            if (Underflow_SO && SymStrb_SO) hit = 1;
         end
         if (!hit) begin
            failures++;
            $display("FAIL uf_timeout: Underflow_SO never rose with a strobe, expected within 40 cycles");
            checks++;
         end
         if (pass == 0) begin
            // The next edge is phase 1: the clear must take effect
            step(1, 1, 3);
            if (Underflow_SO !== 1'b0 || Underflow_SO !== e_uf) begin
               failures++;
               $display("FAIL uf_clear: uf=%b, expected 0", Underflow_SO);
            end
            checks++;
         end else begin
            step(0, 0, 0);
            // The next edge is a phase-0 slot with an empty FIFO: the set must win
            step(1, 1, 3);
            if (Underflow_SO !== 1'b1 || Underflow_SO !== e_uf || SymStrb_SO !== 1'b1 || UPS_Out_DO !== 24'd0) begin
               failures++;
               $display("FAIL uf_setwins: uf=%b strb=%b out=%0d, expected uf=1 strb=1 out=0",
                        Underflow_SO, SymStrb_SO, $signed(UPS_Out_DO));
            end
            checks++;
         end
      end
   endtask

   task automatic test_backpressure();
      int sent[$];
      int got[$];
      bit saw_busy;
      logic [23:0] eo;
      do_reset();
      step(1, 0, 8); step(1, 1, 1);
      for (int i = 0; i < 8; i++) src.push_back(rand_sym());
      sent = src;
      saw_busy = 0;
      for (int i = 0; i < 80; i++) begin
         step(0, 0, 0);
         eo = 24'(e_out);
         if (UPS_Out_DO !== eo || SymStrb_SO !== e_strb || SymReady_SO !== e_ready || Underflow_SO !== e_uf) begin
            failures++;
            $display("FAIL bp_cycle: out=%0d strb=%b rdy=%b uf=%b, expected out=%0d strb=%b rdy=%b uf=%b",
                     $signed(UPS_Out_DO), SymStrb_SO, SymReady_SO, Underflow_SO, e_out, e_strb, e_ready, e_uf);
         end
         checks++;
         if (!SymReady_SO) saw_busy = 1;
         if (SymStrb_SO) got.push_back(int'($signed(UPS_Out_DO)));
      end
      if (saw_busy !== 1'b1) begin
         failures++;
         $display("FAIL bp_full: SymReady_SO never dropped, expected a drop once 4 entries are held");
      end
      checks++;
      for (int i = 0; i < 8; i++) begin
         if (i >= got.size() || got[i] !== sent[i]) begin
            failures++;
            $display("FAIL bp_order[%0d]: got %0d, expected %0d", i, (i < got.size()) ? got[i] : 0, sent[i]);
         end
         checks++;
      end
   endtask

   task automatic test_lchange();
      logic [23:0] eo;
      int strb_at[$];
      bit hit;
      do_reset();
      step(1, 0, 4); step(1, 1, 1);
      for (int i = 0; i < 16; i++) src.push_back(rand_sym());
      hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
         step(0, 0, 0);
         if (SymStrb_SO) hit = 1;
      end
      if (!hit) begin
         failures++;
         $display("FAIL lc_timeout: no strobe within 20 cycles, expected one");
         checks++;
      end
      // The DUT now sits at phase 1; L=2 must take effect only after this period of 4
      for (int i = 1; i <= 10; i++) begin
         if (i == 1) step(1, 0, 2); else if (i == 7) step(1, 0, 0); else step(0, 0, 0);
         eo = 24'(e_out);
         if (UPS_Out_DO !== eo || SymStrb_SO !== e_strb || SymReady_SO !== e_ready || Underflow_SO !== e_uf) begin
            failures++;
            $display("FAIL lc_cycle: out=%0d strb=%b rdy=%b uf=%b, expected out=%0d strb=%b rdy=%b uf=%b",
                     $signed(UPS_Out_DO), SymStrb_SO, SymReady_SO, Underflow_SO, e_out, e_strb, e_ready, e_uf);
         end
         checks++;
         if (SymStrb_SO) strb_at.push_back(i);
      end
      // Strobes at 4, 6, then L=1 (written at 7, taking effect at the phase-0 slot 8): 8, 9, 10
      if (strb_at.size() != 5 || strb_at[0] != 4 || strb_at[1] != 6 || strb_at[2] != 8 ||
          strb_at[3] != 9 || strb_at[4] != 10) begin
         failures++;
         $display("FAIL lc_period: strobe offsets %p, expected '{4,6,8,9,10}", strb_at);
      end
      checks++;
   endtask

   task automatic test_gain_disable();
      int got[$];
      int exp0, exp1, exp2;
      logic [23:0] eo;
      do_reset();
      step(1, 0, 4); step(1, 1, 1);
      src.push_back(24'h100000); src.push_back(-3); src.push_back(24'h300000);
      for (int i = 0; i < 4; i++) src.push_back(rand_sym());
`ifdef UPS_GAIN_EN
      exp0 = 24'h400000; exp1 = -12; exp2 = SMAX;
`else
      exp0 = 24'h100000; exp1 = -3; exp2 = 24'h300000;
`endif
      for (int i = 0; i < 14; i++) begin
         step(0, 0, 0);
         eo = 24'(e_out);
         if (UPS_Out_DO !== eo || SymStrb_SO !== e_strb || SymReady_SO !== e_ready || Underflow_SO !== e_uf) begin
            failures++;
            $display("FAIL gain_cycle: out=%0d strb=%b rdy=%b uf=%b, expected out=%0d strb=%b rdy=%b uf=%b",
                     $signed(UPS_Out_DO), SymStrb_SO, SymReady_SO, Underflow_SO, e_out, e_strb, e_ready, e_uf);
         end
         checks++;
         if (SymStrb_SO) got.push_back(int'($signed(UPS_Out_DO)));
      end
      if (got.size() < 3 || got[0] !== exp0 || got[1] !== exp1 || got[2] !== exp2) begin
         failures++;
         $display("FAIL gain_vals: got %p, expected first three %0d %0d %0d", got, exp0, exp1, exp2);
      end
      checks++;
      // Disable mid-stream: En drops after this edge, outputs and FIFO clear on the next
      step(1, 1, 0);
      step(0, 0, 0);
      if (UPS_Out_DO !== 24'd0 || SymStrb_SO !== 1'b0 || SymReady_SO !== 1'b1 || e_ready !== 1'b1) begin
         failures++;
         $display("FAIL dis_flush: out=%0d strb=%b rdy=%b, expected out=0 strb=0 rdy=1",
                  $signed(UPS_Out_DO), SymStrb_SO, SymReady_SO);
      end
      checks++;
   endtask

   task automatic test_random();
      logic [23:0] eo;
      int r;
      do_reset();
      gap_pct = 30;
      step(1, 0, 24'($urandom_range(5))); step(1, 1, 1);
      for (int i = 0; i < 1500; i++) begin
         while (src.size() < 3) src.push_back(rand_sym());
         r = $urandom_range(99);
         if (r < 3)       step(1, 0, 24'($urandom_range(5)));
         else if (r < 4)  step(1, 1, 24'($urandom_range(1) << 1));
         else if (r < 7)  step(1, 1, 24'(1 | ($urandom_range(1) << 1)));
         else if (r < 8)  step(1, 5'($urandom_range(31, 2)), 24'($urandom));
         else             step(0, 0, 0);
         eo = 24'(e_out);
         if (UPS_Out_DO !== eo || SymStrb_SO !== e_strb || SymReady_SO !== e_ready || Underflow_SO !== e_uf) begin
            failures++;
            $display("FAIL rand_cycle[%0d]: out=%0d strb=%b rdy=%b uf=%b, expected out=%0d strb=%b rdy=%b uf=%b",
                     i, $signed(UPS_Out_DO), SymStrb_SO, SymReady_SO, Underflow_SO, e_out, e_strb, e_ready, e_uf);
         end
         checks++;
      end
   endtask

   initial begin
      Rst_RBI = 1'b0; WrEn_SI = 1'b0; Addr_DI = '0; PAR_In_DI = '0;
      Sym_In_DI = '0; SymValid_SI = 1'b0; gap_pct = 0;
      model_reset();
      #22;
      test_reset();
      test_basic();
      test_underflow();
      test_backpressure();
      test_lchange();
      test_gain_disable();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
